// File: rtl/rbm_pkg.sv
// Shared types and constants for the RBM hidden-unit sampling path.
// Optional build macro used by rbm_hidden_sampler: RBM_HSAMP_POPCNT_EN.
package rbm_pkg;

    // Unsigned probability, 0x0000 = 0.0, 0xFFFF ~ 1.0
    typedef logic [15:0] prob_q0p16_t;

    typedef enum logic [2:0] {
        HS_IDLE,
        HS_LAUNCH,
        HS_WAIT_HI,
        HS_WAIT_LO,
        HS_CAPT,
        HS_PUBLISH
    } hsamp_state_t;

    // Galois taps 32,22,2,1 for a right-shifting register
    localparam logic [31:0] LFSR32_MASK         = 32'h80200003;
    localparam logic [31:0] LFSR32_DEFAULT_SEED = 32'hACE12468;

    // One Galois step: shift right, fold the tap mask in when the bit shifted out is 1
    function automatic logic [31:0] lfsr32_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR32_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/rbm_hidden_sampler_lfsr.sv
// 32-bit Galois LFSR with synchronous reload. Shared by the hidden and
// visible sampling stages. A zero load value would lock the register at
// zero forever, so it is replaced by SEED.
module lfsr32_galois
    import rbm_pkg::*;
#(
    parameter logic [31:0] SEED = LFSR32_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        step,
    output logic [31:0] rnd
);

    // Register update: reset/load take priority, otherwise advance only on step
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            rnd <= SEED;
        end else if (load) begin
            rnd <= (load_val == 32'h0) ? SEED : load_val;
        end else if (step) begin
            rnd <= lfsr32_next(rnd);
        end
    end

endmodule

// File: rtl/rbm_hidden_sampler.sv
// Hidden-unit sequencer and Bernoulli sampler. Walks j = 0..H_DIM-1, runs
// the GEMV/sigmoid core once per j, captures p_j, draws h_s[j] = (rnd < p_j)
// and publishes the full vector over valid/ready.
// Build option: define RBM_HSAMP_POPCNT_EN to get a running popcount of h_s
// on ones_cnt; otherwise ones_cnt is constant 0.
module rbm_hidden_sampler
    import rbm_pkg::*;
#(
    parameter int unsigned H_DIM = 64,
    parameter logic [31:0] SEED  = LFSR32_DEFAULT_SEED
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic [$clog2(H_DIM)-1:0]     hid_sel,
    output logic                         core_start,
    input  logic                         core_busy,
    input  logic [15:0]                  core_p,
    input  logic                         seed_load,
    input  logic [31:0]                  seed_in,
    output logic [H_DIM-1:0][15:0]       h_p,
    output logic [H_DIM-1:0]             h_s,
    output logic                         vec_valid,
    input  logic                         vec_ready,
    output logic [$clog2(H_DIM+1)-1:0]   ones_cnt
);

    localparam int J_W   = $clog2(H_DIM);
    localparam int CNT_W = $clog2(H_DIM+1);
    localparam logic [J_W-1:0] J_LAST = J_W'(H_DIM - 1);

    hsamp_state_t                state;
    prob_q0p16_t [H_DIM-1:0]     work_p;
    logic        [H_DIM-1:0]     work_s;
    logic        [31:0]          rnd;
    logic                        sample;
    logic                        publish;
    logic                        lfsr_load;
    logic                        lfsr_step;

    // Seeding is only honoured while idle; stepping happens once per hidden unit
    assign lfsr_load = (state == HS_IDLE) && seed_load;
    assign lfsr_step = (state == HS_CAPT);
    assign sample    = rnd[15:0] < work_p[hid_sel];
    // Output bank is free when empty or being drained this very cycle
    assign publish   = (state == HS_PUBLISH) && (!vec_valid || vec_ready);

    lfsr32_galois #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (seed_in),
        .step     (lfsr_step),
        .rnd      (rnd)
    );

    // Sweep sequencer with registered busy/core_start/hid_sel
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HS_IDLE;
            busy       <= 1'b0;
            core_start <= 1'b0;
            hid_sel    <= '0;
            // NOTE: the working bank is reset on purpose so a mid-sweep reset leaves no stale data visible anywhere.
            work_p     <= '0;
            work_s     <= '0;
        end else begin
            core_start <= 1'b0;
            unique case (state)
                HS_IDLE: begin
                    if (start) begin
                        state      <= HS_LAUNCH;
                        busy       <= 1'b1;
                        hid_sel    <= '0;
                        core_start <= 1'b1;
                    end
                end
                HS_LAUNCH: begin
                    state <= HS_WAIT_HI;
                end
                HS_WAIT_HI: begin
                    if (core_busy) state <= HS_WAIT_LO;
                end
                HS_WAIT_LO: begin
                    if (!core_busy) begin
                        work_p[hid_sel] <= core_p;
                        state           <= HS_CAPT;
                    end
                end
                HS_CAPT: begin
                    work_s[hid_sel] <= sample;
                    if (hid_sel == J_LAST) begin
                        state <= HS_PUBLISH;
                    end else begin
                        hid_sel    <= hid_sel + J_W'(1);
                        core_start <= 1'b1;
                        state      <= HS_LAUNCH;
                    end
                end
                HS_PUBLISH: begin
                    if (publish) begin
                        state <= HS_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= HS_IDLE;
                end
            endcase
        end
    end

    // Output bank and valid flag; a publish in the drain cycle keeps valid high
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_valid <= 1'b0;
            h_p       <= '0;
            h_s       <= '0;
        end else if (publish) begin
            vec_valid <= 1'b1;
            h_p       <= work_p;
            h_s       <= work_s;
        end else if (vec_ready) begin
            vec_valid <= 1'b0;
        end
    end

`ifdef RBM_HSAMP_POPCNT_EN
    logic [CNT_W-1:0] work_cnt;

    // Running count of ones, one increment per CAPT, copied out alongside h_s
    always_ff @(posedge clk) begin
        if (rst) begin
            work_cnt <= '0;
            ones_cnt <= '0;
        end else begin
            if ((state == HS_IDLE) && start) begin
                work_cnt <= '0;
            end else if (state == HS_CAPT) begin
                work_cnt <= work_cnt + CNT_W'(sample);
            end
            if (publish) ones_cnt <= work_cnt;
        end
    end
`else
    assign ones_cnt = '0;
`endif

endmodule

// File: tb/tb_rbm_hidden_sampler.sv
// Directed bench for rbm_hidden_sampler (H_DIM=4) with a behavioural GEMV
// core model: busy rises the cycle after the launch is seen, stays high for
// a fixed 5 or a random 1..300 cycles, then drops with p_j on core_p.
module tb_rbm_hidden_sampler;

    localparam int H = 4;

`ifdef RBM_HSAMP_POPCNT_EN
    localparam bit POPCNT = 1'b1;
`else
    localparam bit POPCNT = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               busy;
    logic [1:0]         hid_sel;
    logic               core_start;
    logic               core_busy;
    logic [15:0]        core_p;
    logic               seed_load;
    logic [31:0]        seed_in;
    logic [H-1:0][15:0] h_p;
    logic [H-1:0]       h_s;
    logic               vec_valid;
    logic               vec_ready;
    logic [2:0]         ones_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] p_tab [H];
    bit          rand_lat = 1'b0;
    logic [1:0]  start_log [$];

    localparam logic [H-1:0][15:0] P_RAMP = {16'd3072, 16'd2048, 16'd1024, 16'd0};
    localparam logic [H-1:0][15:0] P_HALF = {4{16'h8000}};

    rbm_hidden_sampler #(.H_DIM(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .hid_sel    (hid_sel),
        .core_start (core_start),
        .core_busy  (core_busy),
        .core_p     (core_p),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .h_p        (h_p),
        .h_s        (h_s),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .ones_cnt   (ones_cnt)
    );

    always #5 clk = ~clk;

    // GEMV core model; junk on core_p while busy exposes early capture
    initial begin
        core_busy = 1'b0;
        core_p    = 16'h0;
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                automatic int          lat = rand_lat ? int'($urandom_range(1, 300)) : 5;
                automatic logic [15:0] p   = p_tab[hid_sel];
                start_log.push_back(hid_sel);
                @(negedge clk);
                core_busy = 1'b1;
                core_p    = 16'h5A5A;
                repeat (lat) @(negedge clk);
                core_busy = 1'b0;
                core_p    = p;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_p(input logic [H-1:0][15:0] v);
        for (int i = 0; i < H; i++) p_tab[i] = v[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic kick(input bit with_seed, input logic [31:0] s);
        @(negedge clk);
        start     = 1'b1;
        seed_load = with_seed;
        seed_in   = s;
        @(negedge clk);
        start     = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic consume();
        @(negedge clk);
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
    endtask

    // Waits for vec_valid to rise; reports busy just before and at the rise
    task automatic wait_valid(output bit ok, output logic busy_before, output logic busy_at);
        ok          = 1'b0;
        busy_before = busy;
        busy_at     = 1'bx;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (vec_valid === 1'b1) begin
                ok      = 1'b1;
                busy_at = busy;
            end else begin
                busy_before = busy;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed_in = 32'h0; vec_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (core_start !== 1'b0) begin miscompares++; $display("FAIL rst_core_start: got %b want 0", core_start); end
        vectors++; if (hid_sel !== 2'd0) begin miscompares++; $display("FAIL rst_hid_sel: got %0d want 0", hid_sel); end
        vectors++; if (vec_valid !== 1'b0) begin miscompares++; $display("FAIL rst_vec_valid: got %b want 0", vec_valid); end
        vectors++; if (h_p !== '0) begin miscompares++; $display("FAIL rst_h_p: got %h want 0", h_p); end
        vectors++; if (h_s !== 4'b0) begin miscompares++; $display("FAIL rst_h_s: got %b want 0", h_s); end
        vectors++; if (ones_cnt !== 3'd0) begin miscompares++; $display("FAIL rst_ones_cnt: got %0d want 0", ones_cnt); end
        rst = 1'b0;
    endtask

    // Ramp probabilities, default seed; stray start mid-sweep must be ignored
    task automatic test_basic_sweep();
        bit ok; logic bb, ba; logic [7:0] sel_seq;
        do_reset();
        set_p(P_RAMP);
        start_log.delete();
        kick(1'b0, 32'h0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(ok, bb, ba);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_timeout: vec_valid never rose"); end
        vectors++; if (bb !== 1'b1) begin miscompares++; $display("FAIL basic_busy_before: got %b want 1", bb); end
        vectors++; if (ba !== 1'b0) begin miscompares++; $display("FAIL basic_busy_at_valid: got %b want 0", ba); end
        sel_seq = 8'h00;
        foreach (start_log[i]) if (i < 4) sel_seq[i*2 +: 2] = start_log[i];
        vectors++; if (start_log.size() !== 4) begin miscompares++; $display("FAIL basic_launch_count: got %0d want 4", start_log.size()); end
        vectors++; if (sel_seq !== 8'hE4) begin miscompares++; $display("FAIL basic_hid_seq: got %h want e4", sel_seq); end
        vectors++; if (h_p !== P_RAMP) begin miscompares++; $display("FAIL basic_h_p: got %h want %h", h_p, P_RAMP); end
        // default seed low halves 2468,9234,491A,248D are all above the ramp
        vectors++; if (h_s !== 4'b0000) begin miscompares++; $display("FAIL basic_h_s: got %b want 0000", h_s); end
        vectors++; if (ones_cnt !== 3'd0) begin miscompares++; $display("FAIL basic_ones: got %0d want 0", ones_cnt); end
        vectors++; if (hid_sel !== 2'd3) begin miscompares++; $display("FAIL basic_hid_hold: got %0d want 3", hid_sel); end
        consume();
        repeat (3) @(negedge clk);
        vectors++; if (vec_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain: vec_valid got %b want 0", vec_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_p_extremes();
        bit ok; logic bb, ba;
        do_reset();
        set_p('0);
        kick(1'b0, 32'h0);
        wait_valid(ok, bb, ba);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL pzero_timeout: vec_valid never rose"); end
        vectors++; if (h_s !== 4'b0000) begin miscompares++; $display("FAIL pzero_h_s: got %b want 0000", h_s); end
        consume();
        // seed 1: low halves 0001,0003,0002,0001 are all below 0xFFFF
        set_p({4{16'hFFFF}});
        kick(1'b1, 32'h1);
        wait_valid(ok, bb, ba);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL pfull_timeout: vec_valid never rose"); end
        vectors++; if (h_s !== 4'b1111) begin miscompares++; $display("FAIL pfull_h_s: got %b want 1111", h_s); end
        vectors++; if (ones_cnt !== (POPCNT ? 3'd4 : 3'd0)) begin miscompares++; $display("FAIL pfull_ones: got %0d want %0d", ones_cnt, POPCNT ? 4 : 0); end
        consume();
    endtask

    // Seed 12345678: low halves 5678,2B3C,159E,8ACF -> samples j0..j3 = 1,1,1,0
    task automatic test_seed_load();
        bit ok; logic bb, ba;
        do_reset();
        set_p(P_HALF);
        for (int rep = 0; rep < 2; rep++) begin
            @(negedge clk);
            seed_load = 1'b1;
            seed_in   = 32'h12345678;
            @(negedge clk);
            seed_load = 1'b0;
            kick(1'b0, 32'h0);
            repeat (4) @(negedge clk);
            seed_load = 1'b1;
            seed_in   = 32'h00000001;
            @(negedge clk);
            seed_load = 1'b0;
            wait_valid(ok, bb, ba);
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL seed_timeout rep%0d: vec_valid never rose", rep); end
            vectors++; if (h_s !== 4'b0111) begin miscompares++; $display("FAIL seed_h_s rep%0d: got %b want 0111", rep, h_s); end
            vectors++; if (ones_cnt !== (POPCNT ? 3'd3 : 3'd0)) begin miscompares++; $display("FAIL seed_ones rep%0d: got %0d want %0d", rep, ones_cnt, POPCNT ? 3 : 0); end
            consume();
        end
    endtask

    task automatic test_random_latency();
        bit ok; logic bb, ba;
        do_reset();
        set_p(P_HALF);
        rand_lat = 1'b1;
        kick(1'b1, 32'h12345678);
        wait_valid(ok, bb, ba);
        rand_lat = 1'b0;
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rlat_timeout: vec_valid never rose"); end
        vectors++; if (h_s !== 4'b0111) begin miscompares++; $display("FAIL rlat_h_s: got %b want 0111", h_s); end
        vectors++; if (h_p !== P_HALF) begin miscompares++; $display("FAIL rlat_h_p: got %h want %h", h_p, P_HALF); end
        repeat (310) @(negedge clk);
        consume();
    endtask

    task automatic test_back_to_back();
        bit ok; logic bb, ba;
        do_reset();
        set_p(P_RAMP);
        kick(1'b0, 32'h0);
        wait_valid(ok, bb, ba);
        vectors++; if (h_p !== P_RAMP) begin miscompares++; $display("FAIL b2b_first_h_p: got %h want %h", h_p, P_RAMP); end
        set_p(P_HALF);
        // seed_load and start together: the second sweep must use the new seed
        kick(1'b1, 32'h12345678);
        repeat (100) @(negedge clk);
        vectors++; if (vec_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_stall_valid: got %b want 1", vec_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_stall_busy: got %b want 1", busy); end
        vectors++; if (h_p !== P_RAMP) begin miscompares++; $display("FAIL b2b_stall_h_p: got %h want %h", h_p, P_RAMP); end
        vectors++; if (h_s !== 4'b0000) begin miscompares++; $display("FAIL b2b_stall_h_s: got %b want 0000", h_s); end
        consume();
        vectors++; if (vec_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_reload_valid: got %b want 1", vec_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_reload_busy: got %b want 0", busy); end
        vectors++; if (h_p !== P_HALF) begin miscompares++; $display("FAIL b2b_second_h_p: got %h want %h", h_p, P_HALF); end
        vectors++; if (h_s !== 4'b0111) begin miscompares++; $display("FAIL b2b_second_h_s: got %b want 0111", h_s); end
        consume();
        @(negedge clk);
        vectors++; if (vec_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: vec_valid got %b want 0", vec_valid); end
    endtask

    // Default seed with p=0x8000: low halves 2468,9234,491A,248D -> 1,0,1,1
    task automatic test_reset_mid_sweep();
        bit ok, hit; logic bb, ba;
        do_reset();
        set_p(P_HALF);
        kick(1'b0, 32'h0);
        wait_valid(ok, bb, ba);
        vectors++; if (h_s !== 4'b1101) begin miscompares++; $display("FAIL rmid_first_h_s: got %b want 1101", h_s); end
        start_log.delete();
        kick(1'b0, 32'h0);
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (start_log.size() == 3 && core_busy === 1'b1) hit = 1'b1;
        end
        vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL rmid_reach_j2: core busy for j=2 never seen"); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", busy); end
        vectors++; if (vec_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_vec_valid: got %b want 0", vec_valid); end
        vectors++; if (core_start !== 1'b0) begin miscompares++; $display("FAIL rmid_core_start: got %b want 0", core_start); end
        vectors++; if (h_s !== 4'b0000) begin miscompares++; $display("FAIL rmid_h_s: got %b want 0000", h_s); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        kick(1'b0, 32'h0);
        wait_valid(ok, bb, ba);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rmid_rerun_timeout: vec_valid never rose"); end
        vectors++; if (h_s !== 4'b1101) begin miscompares++; $display("FAIL rmid_rerun_h_s: got %b want 1101", h_s); end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_p_extremes();
        test_seed_load();
        test_random_latency();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rbm_hidden_sampler.md
Name: rbm_hidden_sampler

Overview:
- Sequencer and Bernoulli sampling stage placed directly downstream of the forward GEMV/sigmoid core.
- Sweeps the hidden index j over 0..H_DIM-1. For each j it launches the core once and captures the Q0.16 probability p_j.
- Draws a binary sample h_s[j] = (rnd < p_j) from an internal LFSR.
- Publishes the complete h_p/h_s vector over a valid/ready handshake to the outer-product accumulator.

Parameters:
- H_DIM, 64, number of hidden units per sweep (2..1024).
- SEED, 32'hACE12468, LFSR reset/reload value. Must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a sweep. Sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until the vector is latched into the output bank
- hid_sel  out  $clog2(H_DIM)  current hidden index j; selects the weight column/bias in the wrapper
- core_start  out  1  one-cycle launch pulse to the GEMV core
- core_busy  in  1  GEMV core busy
- core_p  in  16  GEMV core probability, Q0.16. Valid in the first cycle core_busy is low after having been high.
- seed_load  in  1  load seed_in into the LFSR (IDLE only, otherwise ignored)
- seed_in  in  32  replacement seed. A value of 0 is replaced by SEED.
- h_p  out  16 x H_DIM  latched probabilities, Q0.16
- h_s  out  H_DIM  latched binary samples
- vec_valid  out  1  output bank holds an unconsumed vector
- vec_ready  in  1  consumer accepts the vector
- ones_cnt  out  $clog2(H_DIM+1)  popcount of h_s (see Optional Feature)

Behaviour:
- Reset values:
  - busy=0, core_start=0, hid_sel=0, vec_valid=0, h_p all 0, h_s all 0, ones_cnt=0.
  - LFSR=SEED, FSM=IDLE, working bank cleared.
- FSM states: IDLE, LAUNCH, WAIT_HI, WAIT_LO, CAPT, PUBLISH.
- Transitions:
  - IDLE: start -> LAUNCH, j=0.
  - LAUNCH: core_start=1 for exactly this cycle -> WAIT_HI.
  - WAIT_HI: wait until core_busy=1 -> WAIT_LO.
  - WAIT_LO: wait until core_busy=0. In that cycle, register core_p into work_p[j] -> CAPT.
  - CAPT:
    - work_s[j] = (lfsr[15:0] < work_p[j]), unsigned compare.
    - LFSR advances exactly once.
    - If j==H_DIM-1 -> PUBLISH; else j++ and -> LAUNCH.
  - PUBLISH: if vec_valid=0 or vec_ready=1 in this cycle, copy the working bank to h_p/h_s, set vec_valid=1, busy=0 next cycle -> IDLE. Otherwise stall in PUBLISH.
- Handshake:
  - A transfer occurs on a cycle with vec_valid & vec_ready.
  - vec_valid clears the next cycle unless PUBLISH loads a new vector in that same cycle; then it stays 1.
  - h_p/h_s are stable while vec_valid=1 and not transferred.
- Per-hidden latency: 1 (LAUNCH) + core latency + 2 cycles (WAIT_LO capture, CAPT).
- hid_sel equals j from LAUNCH through CAPT. It is held at its last value in IDLE.
- LFSR:
  - 32-bit Galois, taps 32,22,2,1 (mask 32'h80200003).
  - Steps only in CAPT, never while waiting, so samples are deterministic for a given SEED and p sequence.
- Boundary conditions:
  - p=0x0000 gives h_s=0 always.
  - p=0xFFFF gives h_s=1 unless lfsr[15:0]==0xFFFF.
  - start while busy is ignored. seed_load outside IDLE is ignored.
  - start and seed_load in the same IDLE cycle: seed loads first, and the sweep uses the new seed.
  - The core is trusted to complete. No timeout.
  - rst mid-sweep or mid-PUBLISH: everything returns to reset values, including dropping vec_valid and any pending vector.

Optional Feature:
- Macro RBM_HSAMP_POPCNT_EN.
- Defined: ones_cnt holds the popcount of the vector presented on h_s. It is updated in the same cycle as h_s and computed incrementally during CAPT, with no wide adder tree.
- Undefined: ones_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package rbm_pkg:
  - typedefs prob_q0p16_t (logic [15:0]) and the hidden-sampler state enum.
  - localparams LFSR32_MASK=32'h80200003 and LFSR32_DEFAULT_SEED.
- Sub-module lfsr32_galois (clk, rst, load, load_val, step, rnd[31:0]) is natural. It is reused later for visible-unit sampling.

Test Plan:
- Core model (busy for 5 cycles, p_j = j*1024), H_DIM=4, start pulse -> 4 core_start pulses with hid_sel 0,1,2,3; then vec_valid=1 with h_p={0,1024,2048,3072}; busy drops the same cycle vec_valid rises.
- All p=0x0000 -> h_s all 0. All p=0xFFFF with SEED=1 -> h_s all 1; popcount=H_DIM when RBM_HSAMP_POPCNT_EN is defined.
- Two back-to-back sweeps with vec_ready held 0 -> FSM stalls in PUBLISH with the first vector unchanged. Raising vec_ready for 1 cycle -> second vector loaded, vec_valid stays 1.
- seed_load with seed_in=32'h12345678, then a sweep with p=0x8000 -> h_s matches the Python Galois reference bit-for-bit. A repeat with the same seed gives an identical h_s.
- Core busy stretched randomly 1-300 cycles -> h_s identical to the fixed-latency run with the same seed.
- rst asserted in WAIT_LO of j=2 -> next cycle busy=0, vec_valid=0, core_start=0. A new sweep reproduces the first-sweep samples, confirming the LFSR reloaded SEED.
